// File: rtl/alu_uart_pkg.sv
// alu_uart_pkg: state encoding, default widths and ALU opcode constants shared by
// the UART/ALU sequencer and its benches.
package alu_uart_pkg;
    localparam int SIZEDATA_DEF = 8;
    localparam int SIZEOP_DEF   = 6;
    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, SEND} state_e;
endpackage

// File: rtl/alu_seq_timer.sv
// alu_seq_timer: loadable down-counter that parks at zero and flags it; load wins
// over decrement.
module alu_seq_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o
);
    logic [W-1:0] count_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_q <= '0;
        else if (load_i) count_q <= value_i;
        else if (en_i && count_q != '0) count_q <= count_q - 1'b1;
    end
    assign zero_o = count_q == '0;
endmodule

// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: gathers A, B, opcode from UART RX bytes, waits ALU_LAT cycles,
// hands the ALU result to UART TX. Define SEQ_TIMEOUT_EN to abort stalled frames.
module alu_uart_sequencer
    import alu_uart_pkg::*;
#(
    parameter int SIZEDATA = SIZEDATA_DEF,
    parameter int SIZEOP   = SIZEOP_DEF,
    parameter int ALU_LAT  = 2
`ifdef SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1000
`endif
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_rx_done,
    input  logic [SIZEDATA-1:0] i_rx_data,
    input  logic [SIZEDATA-1:0] i_alu_result,
    input  logic                i_tx_done,
    output logic [SIZEDATA-1:0] o_alu_datoa,
    output logic [SIZEDATA-1:0] o_alu_datob,
    output logic [SIZEOP-1:0]   o_alu_opcode,
    output logic [SIZEDATA-1:0] o_tx_result,
    output logic                o_tx_start,
    output logic                o_busy,
    output logic                o_drop,
    output logic                o_timeout
);
    localparam int LW = $clog2(ALU_LAT + 1);
    state_e state_q, state_d;
    logic [SIZEDATA-1:0] a_q, b_q, res_q;
    logic [SIZEOP-1:0] op_q;
    logic rx_prev_q, tx_start_q, drop_q, timeout_q;
    logic rx_edge, accept, sample, lat_zero, to_hit;
    // rx_done is a level; only its rising edge delivers a byte
    assign rx_edge = i_rx_done && !rx_prev_q;
    assign accept  = rx_edge && (state_q == GET_A || state_q == GET_B || state_q == GET_OP);
    assign sample  = state_q == EXEC && lat_zero;
    alu_seq_timer #(.W(LW)) u_lat (
        .clk_i(i_clock),
        .rst_ni(i_reset),
        .load_i(accept && state_q == GET_OP),
        .en_i(state_q == EXEC),
        .value_i(LW'(ALU_LAT - 1)),
        .zero_o(lat_zero)
    );
`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic to_zero;
    alu_seq_timer #(.W(TW)) u_to (
        .clk_i(i_clock),
        .rst_ni(i_reset),
        .load_i(accept),
        .en_i(1'b1),
        .value_i(TW'(TIMEOUT_CYCLES)),
        .zero_o(to_zero)
    );
    // a byte arriving in the expiry cycle still counts
    assign to_hit = to_zero && !accept && (state_q == GET_B || state_q == GET_OP);
`else
    assign to_hit = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        case (state_q)
            GET_A:   state_d = accept ? GET_B : GET_A;
            GET_B:   state_d = accept ? GET_OP : to_hit ? GET_A : GET_B;
            GET_OP:  state_d = accept ? EXEC : to_hit ? GET_A : GET_OP;
            EXEC:    state_d = lat_zero ? SEND : EXEC;
            SEND:    state_d = i_tx_done ? GET_A : SEND;
            default: state_d = GET_A;
        endcase
    end
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= GET_A;
            rx_prev_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            res_q      <= '0;
            tx_start_q <= 1'b0;
            drop_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_prev_q  <= i_rx_done;
            if (accept && state_q == GET_A) a_q <= i_rx_data;
            if (accept && state_q == GET_B) b_q <= i_rx_data;
            if (accept && state_q == GET_OP) op_q <= i_rx_data[SIZEOP-1:0];
            if (sample) res_q <= i_alu_result;
            tx_start_q <= sample;
            drop_q     <= rx_edge && !accept;
            timeout_q  <= to_hit;
        end
    end
    assign o_alu_datoa  = a_q;
    assign o_alu_datob  = b_q;
    assign o_alu_opcode = op_q;
    assign o_tx_result  = res_q;
    assign o_tx_start   = tx_start_q;
    assign o_busy       = state_q == EXEC || state_q == SEND;
    assign o_drop       = drop_q;
    assign o_timeout    = timeout_q;
endmodule
